// File: rtl/etapa_exe_vectorial_if.sv
// rtl/etapa_exe_vectorial_if.sv - ID/EXE operand bus and EXE/WB result bus of the vector execute stage
// The stage itself is the slave; the pipeline/testbench side is the master.
interface etapa_exe_vectorial_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DIR_W  = 5
);
  logic                    valid_in;
  logic [3:0]              opcode_in;
  logic [LANES*LANE_W-1:0] VEC1_in;
  logic [LANES*LANE_W-1:0] VEC2_in;
  logic [LANES-1:0]        VFS_in;
  logic [31:0]             sca1_in;
  logic [15:0]             inmediato_in;
  logic [2:0]              shift_in;
  logic [DIR_W-1:0]        dir_dest_in;
  logic                    flush;
  logic                    stall_out;
  logic                    valid_out;
  logic [LANES*LANE_W-1:0] result_out;
  logic [DIR_W-1:0]        dir_dest_out;
  logic                    wb_en_out;

  modport master (
    output valid_in, opcode_in, VEC1_in, VEC2_in, VFS_in, sca1_in,
           inmediato_in, shift_in, dir_dest_in, flush,
    input  stall_out, valid_out, result_out, dir_dest_out, wb_en_out
  );

  modport slave (
    input  valid_in, opcode_in, VEC1_in, VEC2_in, VFS_in, sca1_in,
           inmediato_in, shift_in, dir_dest_in, flush,
    output stall_out, valid_out, result_out, dir_dest_out, wb_en_out
  );
endinterface

// File: rtl/etapa_exe_vectorial.sv
// rtl/etapa_exe_vectorial.sv - lane-wise SIMD execute stage with iterative vector-by-scalar multiply
// Single-cycle ops register on the accept edge; VMULS runs shift-and-add for LANE_W cycles in MUL.
module etapa_exe_vectorial #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DIR_W  = 5
) (
  input logic                  clk,
  input logic                  rst,
  etapa_exe_vectorial_if.slave bus
);
  localparam int VW    = LANES * LANE_W;
  localparam int CNT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANE_W - 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_VADD  = 4'd1;
  localparam logic [3:0] OP_VSUB  = 4'd2;
  localparam logic [3:0] OP_VAND  = 4'd3;
  localparam logic [3:0] OP_VOR   = 4'd4;
  localparam logic [3:0] OP_VSHL  = 4'd5;
  localparam logic [3:0] OP_VSHR  = 4'd6;
  localparam logic [3:0] OP_VADDS = 4'd7;
  localparam logic [3:0] OP_VADDI = 4'd8;
  localparam logic [3:0] OP_VMULS = 4'd9;

  typedef enum logic {IDLE, MUL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VW-1:0]       mul_a_q, mul_a_d;
  logic [LANE_W-1:0]   mul_b_q, mul_b_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic [DIR_W-1:0]    dir_mul_q, dir_mul_d;
  logic [VW-1:0]       acc_q, acc_d;
  logic                valid_q, valid_d;
  logic                wb_q, wb_d;
  logic [VW-1:0]       result_q, result_d;
  logic [DIR_W-1:0]    dir_q, dir_d;

  logic                is_nop;
  logic [LANE_W-1:0]   lane_a, lane_b, lane_r;
  logic [VW-1:0]       alu_res;
  logic [VW-1:0]       acc_next;
  logic [VW-1:0]       mul_res;

  assign is_nop = (bus.opcode_in == OP_NOP) || (bus.opcode_in > OP_VMULS);

  // Masked-off lanes pass operand A through untouched.
  always_comb begin
    alu_res = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_r  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = bus.VEC1_in[i*LANE_W +: LANE_W];
      lane_b = bus.VEC2_in[i*LANE_W +: LANE_W];
      case (bus.opcode_in)
        OP_VADD:  lane_r = lane_a + lane_b;
        OP_VSUB:  lane_r = lane_a - lane_b;
        OP_VAND:  lane_r = lane_a & lane_b;
        OP_VOR:   lane_r = lane_a | lane_b;
        OP_VSHL:  lane_r = lane_a << bus.shift_in;
        OP_VSHR:  lane_r = lane_a >> bus.shift_in;
        OP_VADDS: lane_r = lane_a + bus.sca1_in[LANE_W-1:0];
        OP_VADDI: lane_r = lane_a + bus.inmediato_in[LANE_W-1:0];
        default:  lane_r = '0;
      endcase
      alu_res[i*LANE_W +: LANE_W] = bus.VFS_in[i] ? lane_r : lane_a;
    end
    if (is_nop) alu_res = '0;
  end

  // One shift-and-add step per MUL cycle, all lanes in parallel.
  always_comb begin
    acc_next = acc_q;
    mul_res  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mul_b_q[cnt_q])
        acc_next[i*LANE_W +: LANE_W] = acc_q[i*LANE_W +: LANE_W]
                                     + (mul_a_q[i*LANE_W +: LANE_W] << cnt_q);
      mul_res[i*LANE_W +: LANE_W] = mask_q[i] ? acc_next[i*LANE_W +: LANE_W]
                                              : mul_a_q[i*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mask_d    = mask_q;
    dir_mul_d = dir_mul_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    wb_d      = wb_q;
    result_d  = result_q;
    dir_d     = dir_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      wb_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            if (bus.opcode_in == OP_VMULS) begin
              state_d   = MUL;
              cnt_d     = '0;
              acc_d     = '0;
              mul_a_d   = bus.VEC1_in;
              mul_b_d   = bus.sca1_in[LANE_W-1:0];
              mask_d    = bus.VFS_in;
              dir_mul_d = bus.dir_dest_in;
            end else begin
              result_d = alu_res;
              dir_d    = bus.dir_dest_in;
              wb_d     = !is_nop;
              valid_d  = 1'b1;
            end
          end
        end
        MUL: begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = mul_res;
            dir_d    = dir_mul_q;
            wb_d     = 1'b1;
            valid_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mask_q    <= '0;
      dir_mul_q <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      wb_q      <= 1'b0;
      result_q  <= '0;
      dir_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mask_q    <= mask_d;
      dir_mul_q <= dir_mul_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      result_q  <= result_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.stall_out    = (state_q == MUL);
  assign bus.valid_out    = valid_q;
  assign bus.wb_en_out    = wb_q;
  assign bus.result_out   = result_q;
  assign bus.dir_dest_out = dir_q;
endmodule

// File: tb/tb_etapa_exe_vectorial.sv
// tb/tb_etapa_exe_vectorial.sv - scoreboard bench for the vector execute stage
module tb_etapa_exe_vectorial;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DIR_W  = 5;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dir;
    logic        wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   busy = 0;
  exp_t sb[$];
  exp_t m_e;
  exp_t o_e;

  etapa_exe_vectorial_if #(.LANES(LANES), .LANE_W(LANE_W), .DIR_W(DIR_W)) bus ();

  etapa_exe_vectorial #(.LANES(LANES), .LANE_W(LANE_W), .DIR_W(DIR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] v1,
                                        input logic [31:0] v2, input logic [3:0] vfs,
                                        input logic [31:0] sca, input logic [15:0] imm,
                                        input logic [2:0] sh);
    logic [31:0] r;
    logic [7:0]  a, b, x;
    r = '0;
    if (op == 4'd0 || op > 4'd9) return r;
    for (int i = 0; i < 4; i++) begin
      a = v1[i*8 +: 8];
      b = v2[i*8 +: 8];
      case (op)
        4'd1: x = a + b;
        4'd2: x = a - b;
        4'd3: x = a & b;
        4'd4: x = a | b;
        4'd5: x = 8'((16'(a) << sh));
        4'd6: x = a >> sh;
        4'd7: x = a + sca[7:0];
        4'd8: x = a + imm[7:0];
        default: x = 8'(16'(a) * 16'(sca[7:0]));
      endcase
      r[i*8 +: 8] = vfs[i] ? x : a;
    end
    return r;
  endfunction

  // Reference model of acceptance, stall and flush; pushes the expected result at accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0;
      sb.delete();
    end else if (bus.flush) begin
      if (busy > 0) begin
        busy = 0;
        sb.delete(sb.size() - 1);
      end
    end else if (busy > 0) begin
      busy = busy - 1;
    end else if (bus.valid_in) begin
      m_e.res = model(bus.opcode_in, bus.VEC1_in, bus.VEC2_in, bus.VFS_in,
                      bus.sca1_in, bus.inmediato_in, bus.shift_in);
      m_e.dir = bus.dir_dest_in;
      m_e.wb  = !(bus.opcode_in == 4'd0 || bus.opcode_in > 4'd9);
      sb.push_back(m_e);
      if (bus.opcode_in == 4'd9) busy = LANE_W;
    end
  end

  always @(negedge clk) begin
    check("stall", bus.stall_out, busy > 0);
    if (busy > 0) begin
      check("valid_in_mul", bus.valid_out, 1'b0);
    end else if (bus.valid_out) begin
      if (sb.size() == 0) begin
        check("spurious_valid", bus.valid_out, 1'b0);
      end else begin
        o_e = sb.pop_front();
        check("result", bus.result_out, o_e.res);
        check("dir", bus.dir_dest_out, o_e.dir);
        check("wb_en", bus.wb_en_out, o_e.wb);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [3:0] vfs, input logic [31:0] sca, input logic [15:0] imm,
                       input logic [2:0] sh, input logic [4:0] dir);
    int n;
    bus.valid_in     = 1'b1;
    bus.opcode_in    = op;
    bus.VEC1_in      = v1;
    bus.VEC2_in      = v2;
    bus.VFS_in       = vfs;
    bus.sca1_in      = sca;
    bus.inmediato_in = imm;
    bus.shift_in     = sh;
    bus.dir_dest_in  = dir;
    n = 0;
    while (bus.stall_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int stall_cnt;
    bus.valid_in = 0; bus.opcode_in = 0; bus.VEC1_in = 0; bus.VEC2_in = 0;
    bus.VFS_in = 0; bus.sca1_in = 0; bus.inmediato_in = 0; bus.shift_in = 0;
    bus.dir_dest_in = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_result", bus.result_out, 32'h0);
    check("rst_dir", bus.dir_dest_out, 5'h0);
    check("rst_wb", bus.wb_en_out, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    drive(4'd1, 32'hFF10_0102, 32'h0120_0304, 4'b1111, 0, 0, 0, 5'd7);
    check("vadd_valid", bus.valid_out, 1'b1);
    check("vadd_result", bus.result_out, 32'h0030_0406);
    check("vadd_dir", bus.dir_dest_out, 5'd7);

    drive(4'd5, 32'h8181_8181, 0, 4'b0101, 0, 0, 3'd1, 5'd3);
    check("vshl_result", bus.result_out, 32'h8102_8102);

    drive(4'd9, 32'h0302_0110, 0, 4'b1111, 32'h0000_0013, 0, 0, 5'd12);
    stall_cnt = 0;
    n = 0;
    while (!bus.valid_out && n < 50) begin
      if (bus.stall_out) stall_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    check("muls_stall_cycles", stall_cnt, 8);
    check("muls_result", bus.result_out, 32'h3926_1330);
    check("muls_dir", bus.dir_dest_out, 5'd12);
    drive(4'd2, 32'h1020_3040, 32'h0102_0304, 4'b1111, 0, 0, 0, 5'd1);
    check("after_muls_accept", bus.valid_out, 1'b1);

    drive(4'd1, 32'h1122_3344, 32'hF0F0_F0F0, 4'b1111, 0, 0, 0, 5'd2);
    drive(4'd2, 32'h0000_0000, 32'h0102_0304, 4'b1011, 0, 0, 0, 5'd3);
    drive(4'd8, 32'hFEFF_0010, 0, 4'b1111, 0, 16'hAB02, 0, 5'd4);
    check("b2b_last_result", bus.result_out, 32'h0001_0212);

    drive(4'd9, 32'h0506_0708, 0, 4'b1111, 32'h0000_0003, 0, 0, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_stall", bus.stall_out, 1'b0);
    check("flush_valid", bus.valid_out, 1'b0);
    drive(4'd0, 32'hDEAD_BEEF, 0, 4'b1111, 0, 0, 0, 5'd5);
    check("nop_valid", bus.valid_out, 1'b1);
    check("nop_wb", bus.wb_en_out, 1'b0);

    drive(4'd4, 32'h0F0F_0F0F, 32'h3030_3030, 4'b1111, 0, 0, 0, 5'd6);
    drive(4'd9, 32'h0102_0304, 0, 4'b1111, 32'h0000_0005, 0, 0, 5'd8);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mul_stall", bus.stall_out, 1'b0);
    check("rst_mul_valid", bus.valid_out, 1'b0);
    check("rst_mul_result", bus.result_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    for (int k = 0; k < 120; k++) begin
      bus.valid_in     = ($urandom_range(0, 3) != 0);
      bus.opcode_in    = 4'($urandom_range(0, 15));
      bus.VEC1_in      = $urandom;
      bus.VEC2_in      = $urandom;
      bus.VFS_in       = 4'($urandom_range(0, 15));
      bus.sca1_in      = $urandom;
      bus.inmediato_in = 16'($urandom);
      bus.shift_in     = 3'($urandom_range(0, 7));
      bus.dir_dest_in  = 5'($urandom_range(0, 31));
      bus.flush        = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
